// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column rotation, debounced press/release, hex encoding.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 20,
  parameter int REPEAT_DELAY = 25,
  parameter int REPEAT_RATE  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] div_q;
  logic [1:0]    col_q, col_d;
  logic [1:0]    rsel_q, rsel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic          tick;
  logic          key_down;
  logic          do_accept;
  logic          do_resume;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rep_q, rep_d, rep_inc;
  logic          armed_q, armed_d;
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd3;
    if (!r[2]) idx = 2'd2;
    if (!r[1]) idx = 2'd1;
    if (!r[0]) idx = 2'd0;
    return idx;
  endfunction

  function automatic logic [3:0] encode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  assign tick     = (div_q == DW'(SCAN_DIV - 1));
  assign key_down = ~row_s2_q[rsel_q];

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    rsel_d    = rsel_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    do_accept = 1'b0;
    do_resume = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d     = rep_q;
    armed_d   = armed_q;
    rep_inc   = rep_q + RW'(1);
`endif
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (row_s2_q != 4'hF) begin
            rsel_d = lowest_low(row_s2_q);
            cnt_d  = CW'(1);
            if (DEBOUNCE_CNT == 1) do_accept = 1'b1;
            else                   state_d   = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (key_down) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(DEBOUNCE_CNT)) do_accept = 1'b1;
          end else begin
            state_d = SCAN;
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
          end
        end
        HELD: begin
          if (!key_down) begin
            if (DEBOUNCE_CNT == 1) begin
              do_resume = 1'b1;
            end else begin
              state_d = RELEASE;
              cnt_d   = CW'(1);
            end
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
            armed_d = 1'b0;
          end else if ((!armed_q && rep_inc == RW'(REPEAT_DELAY)) ||
                       (armed_q && rep_inc == RW'(REPEAT_RATE))) begin
            valid_d = 1'b1;
            rep_d   = '0;
            armed_d = 1'b1;
          end else begin
            rep_d = rep_inc;
`endif
          end
        end
        RELEASE: begin
          if (!key_down) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(DEBOUNCE_CNT)) do_resume = 1'b1;
          end else begin
            // Bounce during release: back to HELD without a new strobe.
            state_d = HELD;
            cnt_d   = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
    if (do_accept) begin
      code_d  = encode(rsel_d, col_q);
      valid_d = 1'b1;
      held_d  = 1'b1;
      state_d = HELD;
      cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
      rep_d   = '0;
      armed_d = 1'b0;
`endif
    end
    if (do_resume) begin
      state_d = SCAN;
      held_d  = 1'b0;
      cnt_d   = '0;
      col_d   = col_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SCAN;
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      div_q    <= '0;
      col_q    <= 2'd0;
      rsel_q   <= 2'd0;
      cnt_q    <= '0;
      code_q   <= 4'h0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q    <= '0;
      armed_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
      div_q    <= tick ? '0 : div_q + DW'(1);
      col_q    <= col_d;
      rsel_q   <= rsel_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      held_q   <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q    <= rep_d;
      armed_q  <= armed_d;
`endif
    end
  end

  assign col       = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed plus random key activity against a tick-level keypad model.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_held;
  logic [15:0] keys = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  // Physical keypad: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  logic [3:0] keymap [16];
  int  cyc, m_col, m_c, m_r, m_lo, m_hi, m_run;
  bit  m_lock, m_held, m_valid;
  logic [3:0] m_code;
  int  pulses_dut, pulses_m;

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] v;
    v = '0;
    v[r*4+c] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_c = 0; m_r = 0; m_lo = 0; m_hi = 0; m_run = 0;
    m_lock = 0; m_held = 0; m_valid = 0; m_code = 4'h0;
  endtask

  task automatic model_accept();
    m_held = 1; m_hi = 0; m_run = 0;
    m_code = keymap[m_r*4+m_c];
    m_valid = 1; pulses_m++;
  endtask

  // One scan tick: the model tracks "which key is locked" plus run lengths of low/high samples.
  task automatic model_tick();
    int c, low_r;
    bit down;
    c = m_lock ? m_c : m_col;
    if (!m_lock) begin
      low_r = -1;
      for (int r = 3; r >= 0; r--) if (keys[r*4+c]) low_r = r;
      if (low_r < 0) m_col = (m_col + 1) % 4;
      else begin
        m_lock = 1; m_c = c; m_r = low_r; m_lo = 1;
        if (m_lo == DB) model_accept();
      end
    end else begin
      down = keys[m_r*4+m_c];
      if (!m_held) begin
        if (down) begin
          m_lo++;
          if (m_lo == DB) model_accept();
        end else begin
          m_lock = 0; m_col = (m_c + 1) % 4;
        end
      end else if (!down) begin
        m_hi++; m_run = 0;
        if (m_hi == DB) begin m_lock = 0; m_held = 0; m_col = (m_c + 1) % 4; end
      end else begin
        m_hi = 0; m_run++;
`ifdef KEYPAD_REPEAT_EN
        if (m_run == RD || (m_run > RD && (m_run - RD) % RR == 0)) begin
          m_valid = 1; pulses_m++;
        end
`endif
      end
    end
  endtask

  task automatic check_outputs();
    logic [1:0] ci;
    logic [3:0] exp_col;
    ci = 2'(m_lock ? m_c : m_col);
    exp_col = ~(4'b0001 << ci);
    chk("col", 16'(col), 16'(exp_col));
    chk("key_code", 16'(key_code), 16'(m_code));
    chk("key_valid", 16'(key_valid), 16'(m_valid));
    chk("key_held", 16'(key_held), 16'(m_held));
  endtask

  task automatic cycle();
    @(posedge clk);
    m_valid = 0;
    if (cyc % SD == SD - 1) model_tick();
    cyc++;
    @(negedge clk);
    check_outputs();
    if (key_valid) pulses_dut++;
  endtask

  task automatic ticks(input int n);
    repeat (n * SD) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_col", 16'(col), 16'hE);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    logic [15:0] k;
    keymap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    pulses_dut = 0; pulses_m = 0; cyc = 0;
    model_reset();
    #2;
    do_reset();

    ticks(5);                                   // idle scan rotation
    keys = key(1, 1);                           // '5'
    ticks(8);
    chk("k5_code", 16'(key_code), 16'h5);
    chk("k5_held", 16'(key_held), 16'h1);

    keys = '0; ticks(1); keys = key(1, 1); ticks(3);   // one-tick release glitch
    chk("glitch_held", 16'(key_held), 16'h1);
    keys = '0; ticks(4);
    chk("release_held", 16'(key_held), 16'h0);

    keys = key(2, 2); ticks(2); keys = '0; ticks(3);   // '9' too short
    chk("short_code", 16'(key_code), 16'h5);

    keys = key(0, 0) | key(2, 0); ticks(8);             // '1' and '7' together
    chk("dual_code", 16'(key_code), 16'h1);
    keys = '0; ticks(4);

    keys = key(3, 1);                                   // reset during debounce
    for (int i = 0; i < 200 && !(m_lock && !m_held); i++) cycle();
    chk("reach_debounce_held", 16'(key_held), 16'h0);
    keys = '0;
    do_reset();
    chk("rst_code", 16'(key_code), 16'h0);
    chk("rst_valid", 16'(key_valid), 16'h0);
    ticks(2);

    for (int n = 0; n < 40; n++) begin
      k = 16'(1) << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) k = k | (16'(1) << $urandom_range(0, 15));
      keys = k;
      ticks($urandom_range(1, 10));
      if ($urandom_range(0, 2) == 0) begin
        keys = '0; ticks(1); keys = k; ticks($urandom_range(1, 4));
      end
      keys = '0;
      ticks($urandom_range(0, 6));
    end
    ticks(6);

`ifdef KEYPAD_REPEAT_EN
    keys = key(3, 2);                                   // '#' held for auto-repeat
    ticks(24);
    chk("rep_code", 16'(key_code), 16'hF);
    keys = '0;
    ticks(6);
`endif

    chk("pulse_total", 16'(pulses_dut), 16'(pulses_m));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
